// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, parallel load and clear,
// with a saturating shift counter and a one-cycle pulse on the WIDTH-th shift.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD0 = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_LOAD  = 3'b011,
    M_ROR   = 3'b100,
    M_ROL   = 3'b101,
    M_CLR   = 3'b110,
    M_HOLD1 = 3'b111
  } mode_t;

  mode_t            op;
  logic [WIDTH-1:0] nxt;
  logic             shift;
  logic             restart;

  assign sout_r = out[0];
  assign sout_l = out[WIDTH-1];

  always_comb begin
    op      = mode_t'(mode);
    nxt     = out;
    shift   = 1'b0;
    restart = 1'b0;
    case (op)
      M_SHR:   begin nxt = {sin_r, out[WIDTH-1:1]};      shift = 1'b1; end
      M_SHL:   begin nxt = {out[WIDTH-2:0], sin_l};      shift = 1'b1; end
      M_ROR:   begin nxt = {out[0], out[WIDTH-1:1]};     shift = 1'b1; end
      M_ROL:   begin nxt = {out[WIDTH-2:0], out[WIDTH-1]}; shift = 1'b1; end
      M_LOAD:  begin nxt = in;  restart = 1'b1; end
      M_CLR:   begin nxt = '0;  restart = 1'b1; end
      default: nxt = out;
    endcase
  end

  // done is cleared every edge and only set on the WIDTH-1 -> WIDTH step,
  // so saturated shifts, holds and disabled cycles all leave it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        out <= nxt;
        if (restart) begin
          cnt <= '0;
        end else if (shift && (cnt < CW'(WIDTH))) begin
          cnt  <= cnt + CW'(1);
          done <= (cnt == CW'(WIDTH - 1));
        end
      end
    end
  end

endmodule
